// File: rtl/sisc_mem_pkg.sv
// Shared definitions for the SISC memory arbiter: port ids, FSM states,
// counter widths and a port-id to one-hot helper.
package sisc_mem_pkg;

    localparam logic [1:0] PORT_IF  = 2'd0;
    localparam logic [1:0] PORT_DM  = 2'd1;
    localparam logic [1:0] PORT_DBG = 2'd2;

    localparam int IF_WAIT_W = 4;
    localparam int LAT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_t;

    function automatic logic [2:0] port_onehot(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

endpackage

// File: rtl/sisc_mem_arb_pick.sv
// Combinational winner selection: DBG > DM > IF, except that a starving IF
// beats DM. Ports in the served-mask are not eligible.
module sisc_mem_arb_pick
    import sisc_mem_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] mask,
    input  logic       starve,
    output logic       valid,
    output logic [1:0] grant
);

    logic [2:0] elig;

    always_comb begin
        elig  = req & ~mask;
        valid = |elig;
        grant = PORT_IF;
        if (elig[PORT_DBG]) begin
            grant = PORT_DBG;
        end else if (elig[PORT_IF] && (starve || !elig[PORT_DM])) begin
            grant = PORT_IF;
        end else if (elig[PORT_DM]) begin
            grant = PORT_DM;
        end
    end

endmodule

// File: rtl/sisc_mem_arbiter.sv
// Single-port memory arbiter for IF, DM and DBG requesters with a fixed
// access latency and a one-cycle one-hot ack to the served port.
//
// state  | meaning
// IDLE   | waiting for an unmasked request; winner latched on the way out
// ACCESS | memory enabled for MEM_LAT cycles, write strobe in the first only
// DONE   | one-cycle ack to the granted port, rdata holds captured data
module sisc_mem_arbiter
    import sisc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
        $error("sisc_mem_arbiter: MEM_LAT must be in 1..15");
    end

    arb_state_t           state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [1:0]           grant_q;
    logic [2:0]           mask_q;
    logic [IF_WAIT_W-1:0] wait_q;
    logic [ADDR_W-1:0]    addr_q, sel_addr;
    logic [DATA_W-1:0]    wdata_q, sel_wdata;
    logic                 we_q, sel_we, first_q;
    logic                 pick_valid, starve, take, capture;
    logic [1:0]           pick_id;

    assign starve = (32'(wait_q) >= STARVE_MAX);

    sisc_mem_arb_pick u_pick (
        .req    ({dbg_req, dm_req, if_req}),
        .mask   (mask_q),
        .starve (starve),
        .valid  (pick_valid),
        .grant  (pick_id)
    );

    // IF is a read-only port, so its write data and enable are forced to 0.
    always_comb begin
        sel_addr  = if_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
        case (pick_id)
            PORT_DM: begin
                sel_addr  = dm_addr;
                sel_wdata = dm_wdata;
                sel_we    = dm_we;
            end
            PORT_DBG: begin
                sel_addr  = dbg_addr;
                sel_wdata = dbg_wdata;
                sel_we    = dbg_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        take    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACCESS;
                    lat_d   = LAT_W'(MEM_LAT - 1);
                    take    = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (lat_q == '0) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            grant_q <= PORT_IF;
            mask_q  <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            first_q <= 1'b0;
            rdata   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            first_q <= take;
            if (take) begin
                grant_q <= pick_id;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                we_q    <= sel_we;
            end
            if (capture) begin
                rdata <= mem_rdata;
            end
            // Served port sits out exactly the IDLE cycle that follows DONE.
            mask_q <= (state_q == ST_DONE) ? port_onehot(grant_q) : 3'b000;
            if (take && pick_id == PORT_IF) begin
                wait_q <= '0;
            end else if (if_req && grant_q != PORT_IF && wait_q != '1) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en && first_q && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign ack       = (state_q == ST_DONE) ? port_onehot(grant_q) : 3'b000;

endmodule

// File: tb/tb_sisc_mem_arbiter.sv
// Bench for sisc_mem_arbiter: directed vectors, priority/starvation/reset
// sequences, a MEM_LAT=1 instance, and randomized traffic against a model.
module tb_sisc_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int LAT1 = 1;
    localparam int SMAX = 4;
    localparam int RAND_CYCLES = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0, dbg_addr = '0;
    logic [DW-1:0] dm_wdata = '0, dbg_wdata = '0, mem_rdata = '0;

    logic [2:0]    ack, ack1;
    logic [DW-1:0] rdata, rdata1, mem_wdata, mem_wdata1;
    logic          busy, busy1, mem_en, mem_en1, mem_we, mem_we1;
    logic [AW-1:0] mem_addr, mem_addr1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sisc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .ack(ack), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    sisc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SMAX)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .ack(ack1), .rdata(rdata1), .busy(busy1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [2:0]  exp_ack;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        dbg_req = 1'b0;
    endtask

    task automatic do_reset;
        clear_reqs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Unselected ports get inverted decoy fields so a wrong mux choice shows up.
    task automatic drive_port(input logic [1:0] p, input logic we, input logic [15:0] a,
                              input logic [31:0] wd);
        clear_reqs();
        if_addr = ~a; dm_addr = ~a; dbg_addr = ~a;
        dm_wdata = ~wd; dbg_wdata = ~wd; dm_we = ~we; dbg_we = ~we;
        case (p)
            2'd0: begin if_req = 1'b1; if_addr = a; end
            2'd1: begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; end
            default: begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
        endcase
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [31:0] exp_wd;
        exp_wd = (v.port == 2'd0) ? 32'h0 : v.wdata;
        drive_port(v.port, v.we, v.addr, v.wdata);
        mem_rdata = v.rd;
        @(negedge clk);
        check($sformatf("%s_idle", tag), 128'({busy, mem_en}), 128'(2'b00));
        for (int k = 1; k <= LAT + 1; k++) begin
            next_cycle();
            @(negedge clk);
            if (k <= LAT)
                check($sformatf("%s_access%0d", tag, k),
                      128'({mem_en, mem_we, mem_addr, mem_wdata, ack}),
                      128'({1'b1, (k == 1) && v.we, v.addr, exp_wd, 3'b000}));
            else
                check($sformatf("%s_ack", tag), 128'({ack, rdata, busy}),
                      128'({v.exp_ack, v.rd, 1'b1}));
        end
        next_cycle();
        clear_reqs();
        @(negedge clk);
        check($sformatf("%s_after", tag), 128'({ack, busy, mem_en, rdata}),
              128'({3'b000, 1'b0, 1'b0, v.rd}));
        next_cycle();
    endtask

    task automatic run_three(input string tag, input int e_dbg, input int e_dm, input int e_if);
        int seen[3];
        logic [2:0] last_ack;
        seen = '{-1, -1, -1};
        last_ack = 3'b000;
        mem_rdata = 32'h5A5A_5A5A;
        if_addr = 16'h0A00; dm_addr = 16'h0B00; dbg_addr = 16'h0C00;
        dm_we = 1'b0; dbg_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; dbg_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (last_ack[0]) if_req = 1'b0;
            if (last_ack[1]) dm_req = 1'b0;
            if (last_ack[2]) dbg_req = 1'b0;
            @(negedge clk);
            last_ack = ack;
            if (ack != 3'b000) begin
                check($sformatf("%s_onehot_c%0d", tag, c), 128'($onehot(ack)), 128'(1));
                for (int p = 0; p < 3; p++)
                    if (ack[p] && seen[p] < 0) seen[p] = c;
            end
            next_cycle();
        end
        clear_reqs();
        check($sformatf("%s_dbg_cycle", tag), 128'(seen[2]), 128'(e_dbg));
        check($sformatf("%s_dm_cycle", tag), 128'(seen[1]), 128'(e_dm));
        check($sformatf("%s_if_cycle", tag), 128'(seen[0]), 128'(e_if));
    endtask

    // Randomized traffic against a transaction-level model.
    bit          pend[3];
    logic [15:0] r_addr[3];
    logic        r_we[3];
    logic [31:0] r_wd[3];
    bit          m_act, m_we;
    int          m_start, m_grant, m_last, m_mask, m_wait;
    logic [15:0] m_addr;
    logic [31:0] m_wd, m_rd;

    task automatic run_random;
        logic [2:0]  prev_ack, e_ack;
        logic        e_en, e_we, e_busy;
        logic [15:0] e_addr;
        logic [31:0] e_wd;
        bit          elig[3];
        int          ph, w, nw, nmask;
        prev_ack = 3'b000;
        m_act = 0; m_last = 0; m_mask = -1; m_wait = 0; m_rd = '0;
        m_start = 0; m_grant = 0; m_we = 0; m_addr = '0; m_wd = '0;
        for (int p = 0; p < 3; p++) pend[p] = 0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            for (int p = 0; p < 3; p++) begin
                if (pend[p] && prev_ack[p]) pend[p] = 0;
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]   = 1;
                    r_addr[p] = 16'($urandom);
                    r_we[p]   = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                    r_wd[p]   = $urandom;
                end
            end
            if_req = pend[0]; if_addr = r_addr[0];
            dm_req = pend[1]; dm_addr = r_addr[1]; dm_we = r_we[1]; dm_wdata = r_wd[1];
            dbg_req = pend[2]; dbg_addr = r_addr[2]; dbg_we = r_we[2]; dbg_wdata = r_wd[2];
            mem_rdata = $urandom;
            @(negedge clk);
            ph     = c - m_start;
            e_busy = m_act;
            e_en   = m_act && ph < LAT;
            e_we   = e_en && ph == 0 && m_we;
            e_addr = e_en ? m_addr : 16'h0;
            e_wd   = e_en ? m_wd : 32'h0;
            e_ack  = (m_act && ph == LAT) ? 3'(1 << m_grant) : 3'b000;
            check($sformatf("rand_c%0d", c),
                  128'({ack, busy, mem_en, mem_we, mem_addr, mem_wdata, rdata}),
                  128'({e_ack, e_busy, e_en, e_we, e_addr, e_wd, m_rd}));
            prev_ack = e_ack;
            nw = m_wait;
            if (pend[0] && m_last != 0) nw = (m_wait >= 15) ? 15 : m_wait + 1;
            nmask = -1;
            if (m_act) begin
                if (ph == LAT - 1) m_rd = mem_rdata;
                if (ph == LAT) begin
                    m_act = 0;
                    nmask = m_grant;
                end
            end else begin
                for (int p = 0; p < 3; p++) elig[p] = pend[p] && (m_mask != p);
                w = -1;
                if (elig[2]) w = 2;
                else if (elig[1] && elig[0]) w = (m_wait >= SMAX) ? 0 : 1;
                else if (elig[1]) w = 1;
                else if (elig[0]) w = 0;
                if (w >= 0) begin
                    m_act = 1; m_start = c + 1; m_grant = w; m_last = w;
                    m_we = r_we[w]; m_addr = r_addr[w];
                    m_wd = (w == 0) ? 32'h0 : r_wd[w];
                    if (w == 0) nw = 0;
                end
            end
            m_mask = nmask;
            m_wait = nw;
            next_cycle();
        end
        clear_reqs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int m;
        vecs[0] = '{2'd0, 1'b0, 16'h0010, 32'h0000_0000, 32'hDEAD_BEEF, 3'b001};
        vecs[1] = '{2'd1, 1'b1, 16'h0100, 32'h1234_5678, 32'hAAAA_5555, 3'b010};
        vecs[2] = '{2'd1, 1'b0, 16'h0200, 32'h0BAD_0BAD, 32'h0F0F_0F0F, 3'b010};
        vecs[3] = '{2'd2, 1'b1, 16'hFFFF, 32'hCAFE_F00D, 32'h1111_1111, 3'b100};
        vecs[4] = '{2'd2, 1'b0, 16'h8001, 32'h0000_0000, 32'h8000_0001, 3'b100};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 128'({ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
        check("reset_state_lat1", 128'({ack1, rdata1, busy1, mem_en1, mem_we1, mem_addr1, mem_wdata1}), 128'(0));
        next_cycle();

        run_three("prio", LAT + 1, 2 * LAT + 3, 3 * LAT + 5);
        repeat (2) next_cycle();

        for (int i = 0; i < 5; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        apply_vec(vecs[2], "pre_starve");
        run_three("starve", LAT + 1, 3 * LAT + 5, 2 * LAT + 3);
        repeat (2) next_cycle();

        drive_port(2'd1, 1'b1, 16'h0100, 32'h1234_5678);
        next_cycle();
        @(negedge clk);
        check("rst_mid_we_first", 128'({mem_en, mem_we}), 128'(2'b11));
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 128'({ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
        clear_reqs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ack != 3'b000 || busy || mem_we) bad++;
            next_cycle();
        end
        check("rst_mid_no_ack", 128'(bad), 128'(0));
        apply_vec(vecs[0], "after_rst");

        do_reset();
        if_req = 1'b1;
        if_addr = 16'h0042;
        for (int c = 0; c < 16; c++) begin
            m = c % (LAT1 + 3);
            @(negedge clk);
            check($sformatf("lat1_c%0d", c), 128'({ack1, mem_en1}),
                  128'({(m == LAT1 + 1) ? 3'b001 : 3'b000, (m >= 1 && m <= LAT1)}));
            next_cycle();
        end
        clear_reqs();
        repeat (3) next_cycle();

        do_reset();
        run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
